// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//   Central sequencer for the 5-stage pipeline register enables and flushes.
//   Combines the ID-stage hazard stall, ID-resolved branch/jump redirects and a
//   fixed-latency mul/div unit in EX. It also keeps saturating stall/flush
//   performance counters.
//
// Parameters
//   MD_CYCLES  total EX freeze cycles per mul/div op, issue cycle included (2..15)
//   CNT_W      width of each performance counter
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   stall_hz      hazard-detector stall request (combinational)
//   br_taken_ID   taken branch/jump resolved in ID
//   md_start_EX   mul/div instruction in EX this cycle
//   cnt_clr       synchronous clear of both counters
//   pc_wr_en, ifid_wr_en, idex_wr_en       pipeline register write enables
//   ifid_flush, idex_bubble, exmem_bubble  NOP insertion controls
//   md_busy       controller is waiting on the mul/div unit
//   md_done       last freeze cycle; result lands in EX/MEM at the next edge
//   stall_cnt     cycles with the PC held (BOOT excluded), saturating
//   flush_cnt     cycles with an IF/ID flush in RUN, saturating
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_hz,
  input  logic             br_taken_ID,
  input  logic             md_start_EX,
  input  logic             cnt_clr,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             ifid_flush,
  output logic             idex_wr_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  // The issue cycle counts as the first freeze cycle, and md_cnt == 0 marks
  // the last MD_WAIT cycle, hence the load value of MD_CYCLES-2.
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

  state_t           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // Next state and per-cycle controls. Defaults are the BOOT/reset values,
  // so an asynchronous reset drives the outputs without waiting for a clock.
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_wr_en     = 1'b0;
    ifid_wr_en   = 1'b0;
    idex_wr_en   = 1'b0;
    ifid_flush   = 1'b1;
    idex_bubble  = 1'b1;
    exmem_bubble = 1'b1;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (md_start_EX) begin
          // Freeze the front end; hazards/redirects re-present afterwards.
          exmem_bubble = 1'b1;
          md_cnt_d     = MD_LOAD;
          state_d      = MD_WAIT;
        end else if (stall_hz) begin
          // Branch operands are not valid yet, so no redirect during a stall.
          idex_bubble = 1'b1;
          idex_wr_en  = 1'b1;
        end else begin
          pc_wr_en   = 1'b1;
          ifid_wr_en = 1'b1;
          idex_wr_en = 1'b1;
          ifid_flush = br_taken_ID;
        end
      end
      MD_WAIT: begin
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b1;
        md_busy      = 1'b1;
        if (md_cnt_q == 4'd0) begin
          md_done = 1'b1;
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    stall_inc   = (state_q != BOOT) && !pc_wr_en;
    flush_inc   = (state_q == RUN) && ifid_flush;
    stall_cnt_d = cnt_clr ? '0 : sat_inc(stall_cnt_q, stall_inc);
    flush_cnt_d = cnt_clr ? '0 : sat_inc(flush_cnt_q, flush_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  a_ifid_needs_pc : assert property (@(posedge clk) disable iff (rst)
    !(ifid_wr_en && !pc_wr_en));
  a_single_bubble : assert property (@(posedge clk) disable iff (rst)
    !((state_q == RUN) && idex_bubble && exmem_bubble));

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  // Output vector: {pc, ifid_wr, ifid_flush, idex_wr, idex_bubble, exmem_bubble, md_busy, md_done}
  localparam logic [7:0] V_BOOT  = 8'b0010_1100;
  localparam logic [7:0] V_IDLE  = 8'b1101_0000;
  localparam logic [7:0] V_STALL = 8'b0001_1000;
  localparam logic [7:0] V_BR    = 8'b1111_0000;
  localparam logic [7:0] V_ISSUE = 8'b0000_0100;
  localparam logic [7:0] V_WAIT  = 8'b0000_0110;
  localparam logic [7:0] V_DONE  = 8'b0000_0111;

  logic clk = 1'b0;
  logic rst, stall_hz, br_taken_ID, md_start_EX, cnt_clr;
  logic pc_wr_en, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble, exmem_bubble;
  logic md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] outv;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_hz(stall_hz), .br_taken_ID(br_taken_ID),
    .md_start_EX(md_start_EX), .cnt_clr(cnt_clr),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
    .idex_wr_en(idex_wr_en), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outv = {pc_wr_en, ifid_wr_en, ifid_flush, idex_wr_en,
                 idex_bubble, exmem_bubble, md_busy, md_done};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       st, br, md, clr;
    logic [7:0] ov;
    int         sc, fc;
  } vec_t;

  vec_t tbl[27];

  // Reference model: a boot flag, the number of MD_WAIT cycles still owed,
  // and the two counters as plain integers.
  bit m_boot;
  int m_wait, m_sc, m_fc;

  initial begin
    tbl[0]  = '{1, 1, 1, 0, V_BOOT,  0, 0};  // BOOT ignores all inputs
    tbl[1]  = '{0, 0, 0, 0, V_IDLE,  0, 0};
    tbl[2]  = '{1, 0, 0, 0, V_STALL, 0, 0};  // load-use pulse
    tbl[3]  = '{0, 0, 0, 0, V_IDLE,  1, 0};
    tbl[4]  = '{1, 1, 0, 0, V_STALL, 1, 0};  // stall beats branch
    tbl[5]  = '{0, 1, 0, 0, V_BR,    2, 0};
    tbl[6]  = '{0, 0, 0, 0, V_IDLE,  2, 1};
    tbl[7]  = '{1, 1, 1, 0, V_ISSUE, 2, 1};  // mul/div beats stall+branch
    tbl[8]  = '{1, 1, 0, 0, V_WAIT,  3, 1};
    tbl[9]  = '{1, 1, 0, 0, V_WAIT,  4, 1};
    tbl[10] = '{1, 1, 1, 0, V_DONE,  5, 1};  // md_start ignored on done cycle
    tbl[11] = '{0, 1, 0, 0, V_BR,    6, 1};  // held branch redirects now
    tbl[12] = '{0, 0, 1, 0, V_ISSUE, 6, 2};
    tbl[13] = '{0, 0, 0, 0, V_WAIT,  7, 2};
    tbl[14] = '{0, 0, 0, 0, V_WAIT,  8, 2};
    tbl[15] = '{0, 0, 0, 0, V_DONE,  9, 2};
    tbl[16] = '{0, 0, 1, 0, V_ISSUE, 10, 2}; // back-to-back mul/div
    tbl[17] = '{0, 0, 0, 0, V_WAIT,  11, 2};
    tbl[18] = '{0, 0, 0, 0, V_WAIT,  12, 2};
    tbl[19] = '{0, 0, 0, 0, V_DONE,  13, 2};
    tbl[20] = '{0, 0, 0, 0, V_IDLE,  14, 2};
    tbl[21] = '{1, 0, 0, 0, V_STALL, 14, 2};
    tbl[22] = '{1, 0, 0, 0, V_STALL, 15, 2};
    tbl[23] = '{1, 0, 0, 0, V_STALL, 15, 2}; // saturated
    tbl[24] = '{1, 0, 0, 1, V_STALL, 15, 2}; // clear beats increment
    tbl[25] = '{1, 0, 0, 0, V_STALL, 0, 0};
    tbl[26] = '{0, 0, 0, 0, V_IDLE,  1, 0};

    rst = 1'b1; stall_hz = 1'b0; br_taken_ID = 1'b0; md_start_EX = 1'b0; cnt_clr = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("reset%0d outs", i), 32'(outv), 32'(V_BOOT));
      chk($sformatf("reset%0d stall_cnt", i), 32'(stall_cnt), 0);
    end

    // Directed vector table
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      if (i == 0) rst = 1'b0;
      stall_hz = tbl[i].st; br_taken_ID = tbl[i].br;
      md_start_EX = tbl[i].md; cnt_clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d outs", i), 32'(outv), 32'(tbl[i].ov));
      chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].sc));
      chk($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].fc));
    end

    // Asynchronous reset in the second MD_WAIT cycle
    @(posedge clk); #1;
    stall_hz = 1'b0; br_taken_ID = 1'b0; cnt_clr = 1'b0; md_start_EX = 1'b1;
    @(negedge clk);
    chk("mdrst issue", 32'(outv), 32'(V_ISSUE));
    @(posedge clk); #1;
    md_start_EX = 1'b0;
    @(negedge clk);
    chk("mdrst wait1", 32'(outv), 32'(V_WAIT));
    @(posedge clk); #1;
    chk("mdrst wait2", 32'(outv), 32'(V_WAIT));
    chk("mdrst pre stall_cnt", 32'(stall_cnt), 3);
    rst = 1'b1;
    #1;
    chk("mdrst async outs", 32'(outv), 32'(V_BOOT));
    chk("mdrst async busy", 32'(md_busy), 0);
    chk("mdrst async stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mdrst boot", 32'(outv), 32'(V_BOOT));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mdrst run", 32'(outv), 32'(V_IDLE));
    chk("mdrst run stall_cnt", 32'(stall_cnt), 0);

    // Randomized run against the reference model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [7:0] ev;
      bit pc_hold, flush_ev;
      @(posedge clk); #1;
      rst         = (cyc == 0) || ($urandom_range(0, 199) == 0);
      stall_hz    = ($urandom_range(0, 2) == 0);
      br_taken_ID = ($urandom_range(0, 2) == 0);
      md_start_EX = ($urandom_range(0, 7) == 0);
      cnt_clr     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      if (rst) begin
        m_boot = 1'b1; m_wait = 0; m_sc = 0; m_fc = 0;
      end
      pc_hold = 1'b0; flush_ev = 1'b0;
      if (rst || m_boot) begin
        ev = V_BOOT;
      end else if (m_wait > 0) begin
        ev = (m_wait == 1) ? V_DONE : V_WAIT;
        pc_hold = 1'b1;
      end else if (md_start_EX) begin
        ev = V_ISSUE;
        pc_hold = 1'b1;
      end else if (stall_hz) begin
        ev = V_STALL;
        pc_hold = 1'b1;
      end else if (br_taken_ID) begin
        ev = V_BR;
        flush_ev = 1'b1;
      end else begin
        ev = V_IDLE;
      end
      chk($sformatf("rand%0d outs", cyc), 32'(outv), 32'(ev));
      chk($sformatf("rand%0d stall_cnt", cyc), 32'(stall_cnt), 32'(m_sc));
      chk($sformatf("rand%0d flush_cnt", cyc), 32'(flush_cnt), 32'(m_fc));
      // Advance the model across the coming clock edge
      if (!rst) begin
        if (m_boot) m_boot = 1'b0;
        else if (m_wait > 0) m_wait--;
        else if (md_start_EX) m_wait = MD_CYCLES - 1;
        if (cnt_clr) begin
          m_sc = 0; m_fc = 0;
        end else begin
          if (pc_hold && m_sc < CNT_MAX) m_sc++;
          if (flush_ev && m_fc < CNT_MAX) m_fc++;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
